if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Sequences instruction-memory fetches for the IF stage. Each fetch uses a req/gnt/rvalid handshake, and only one request is outstanding at a time. The block drives the PC-update controls (pc_write, pc_sel, pc_target), which feed the PC register's IF_Write / PCSrc / PCTarget inputs. It delivers the fetched instruction to the IF/ID boundary with a valid/ready handshake, absorbs redirects from EX, discards stale responses, and flags memory timeouts.

Parameters:
XLEN, 32, address/instruction width
TIMEOUT, 16, max cycles in WAIT/DRAIN without rvalid before error (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
f_pc_current  in  XLEN  current PC from the PC register
redirect  in  1  one-cycle pulse from EX: taken branch/jump
redirect_target  in  XLEN  redirect address, valid with redirect
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (= f_pc_current while imem_req)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  XLEN  response instruction
if_valid  out  1  instruction available to ID
if_instr  out  XLEN  registered instruction
if_pc  out  XLEN  registered address of if_instr
id_ready  in  1  ID accepts instruction this cycle
pc_write  out  1  PC register enable (IF_Write)
pc_sel  out  1  0: PC+4, 1: pc_target (PCSrc)
pc_target  out  XLEN  = redirect_target (combinational)
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; timeout counter=0. if_valid, if_instr, if_pc, fetch_err all 0. rst dominates every other input.
- imem_req = (state==REQ). imem_addr = f_pc_current. pc_target = redirect_target always.
- Without a redirect: pc_write = imem_req & imem_gnt, pc_sel=0. The PC therefore advances by 4 on grant.
- A redirect outside ERR forces pc_write=1 and pc_sel=1 that cycle, overriding any grant-driven update.
- IDLE: go to REQ next cycle.
- REQ:
  - On gnt: latch req_pc=f_pc_current, clear counter, go to WAIT.
  - If redirect arrives with gnt: the granted access is stale; go to DRAIN.
  - If redirect arrives without gnt: stay in REQ; the address follows the new PC next cycle. imem_req/imem_addr change only on gnt or redirect.
- WAIT:
  - On rvalid without redirect: register if_instr=imem_rdata and if_pc=req_pc; go to OUT. if_valid is 1 starting next cycle.
  - Redirect without rvalid: go to DRAIN.
  - Redirect with rvalid in the same cycle: discard the data, go to REQ.
- DRAIN: the outstanding response is discarded on rvalid, then go to REQ. A further redirect updates the PC and stays in DRAIN.
- OUT: if_valid=1, with if_instr/if_pc held stable.
  - id_ready=1: transfer completes, if_valid=0 next cycle, go to REQ.
  - Redirect (with or without id_ready): flush, if_valid=0 next cycle, go to REQ.
- Timeout: the counter increments each cycle in WAIT/DRAIN without rvalid. When it reaches TIMEOUT-1 with no rvalid: fetch_err=1, go to ERR.
- ERR: imem_req=0, pc_write=0, if_valid=0. Redirects and responses are ignored. Exit only via rst.
- A stray rvalid in IDLE/REQ/OUT/ERR is ignored.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, OUT). From reset deassertion to first if_valid is 3 cycles with immediate gnt and rvalid one cycle later.

Test Plan:
- Reset then run: PC=0x0, gnt immediate, rvalid one cycle later with rdata=0x00500093. Required: if_valid=1 at cycle 3, if_instr=0x00500093, if_pc=0x0, pc_write pulse at cycle 1 with pc_sel=0.
- Stall: hold id_ready=0 for 5 cycles in OUT. Required: if_valid, if_instr, if_pc stable, no imem_req. After id_ready=1, the next REQ is issued with addr=0x4.
- Redirect in WAIT: redirect_target=0x100, rvalid arrives 2 cycles later with 0xDEADBEEF. Required: pc_write=1/pc_sel=1 in the redirect cycle, 0xDEADBEEF never appears on if_instr, next request has imem_addr=0x100.
- Simultaneous cases:
  - Redirect + rvalid in WAIT: data dropped, next state REQ.
  - Redirect + gnt in REQ: DRAIN entered, pc_sel=1.
  - Redirect + id_ready in OUT: if_valid=0 next cycle.
- Timeout: gnt given, rvalid withheld, TIMEOUT=16. Required: fetch_err=1 after 16 WAIT cycles, imem_req=0 thereafter, redirect ignored, and rst clears everything back to IDLE.
- Reset mid-WAIT: assert rst while a response is pending. Required: all outputs 0 next cycle; a late rvalid in IDLE/REQ is ignored.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle between the IF fetch controller, the instruction memory and the ID stage.
// "master" is the fetch-controller side; "slave" is the memory/ID side.
interface if_fetch_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding req/gnt/rvalid access, PC update control,
// redirect handling with stale-response draining, and a sticky memory timeout.
module if_fetch_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        f_pc_current,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_target,
  if_fetch_ctrl_if.master        bus,
  output logic                   pc_write,
  output logic                   pc_sel,
  output logic [XLEN-1:0]        pc_target,
  output logic                   fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic [XLEN-1:0]  instr_q,  instr_d;
  logic [XLEN-1:0]  pc_q,     pc_d;
  logic             err_q,    err_d;

  logic grant;
  logic timeout_hit;

  assign bus.imem_req  = (state_q == S_REQ);
  assign bus.imem_addr = f_pc_current;
  assign bus.if_valid  = (state_q == S_OUT);
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = pc_q;
  assign pc_target     = redirect_target;
  assign fetch_err     = err_q;

  assign grant       = bus.imem_req & bus.imem_gnt;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // A redirect always wins over the grant-driven PC+4 step; ERR freezes the PC.
  always_comb begin
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    if (state_q != S_ERR) begin
      if (redirect) begin
        pc_write = 1'b1;
        pc_sel   = 1'b1;
      end else begin
        pc_write = grant;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (bus.imem_gnt) begin
          req_pc_d = f_pc_current;
          cnt_d    = '0;
          // A grant coinciding with a redirect fetches the wrong path; drain it.
          state_d  = redirect ? S_DRAIN : S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (redirect) begin
            state_d = S_REQ;
          end else begin
            instr_d = bus.imem_rdata;
            pc_d    = req_pc_q;
            state_d = S_OUT;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (redirect) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        if (redirect || bus.id_ready) begin
          state_d = S_REQ;
        end
      end

      S_ERR: state_d = S_ERR;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_pc_q <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
    end
  end

endmodule
